ac97_link_engine: RTL and testbench
===================================

AC97_LINK_ENGINE -- requirements
Module: ac97_link_engine

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 12, legal range 1..12: slots 1..NUM_SLOTS exposed; higher slots are always sent invalid and zero.
REQ-002 SHALL have parameter READY_FRAMES, default 2, legal range 1..15: consecutive codec-ready frames needed before RUN.
REQ-003 SHALL have port ac97_bitclk, input, 1 bit: codec bit clock, the single clock.
REQ-004 SHALL have port ac97_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port ac97_sdata_in, input, 1 bit: serial data from the codec.
REQ-006 SHALL have port ac97_sdata_out, output, 1 bit: registered serial data to the codec.
REQ-007 SHALL have port ac97_sync, output, 1 bit: registered frame sync.
REQ-008 SHALL have port ac97_reset_b, output, 1 bit: codec cold reset, equal to NOT ac97_rst, combinational.
REQ-009 SHALL have port ac97_strobe, output, 1 bit: high in the last bit cycle of each frame; outbound slots are sampled at the end of that cycle.
REQ-010 SHALL have port out_slot_data, input, NUM_SLOTS*20 bits: slot k occupies bits [20k-1:20(k-1)].
REQ-011 SHALL have port out_slot_valid, input, NUM_SLOTS bits: bit k-1 is the valid flag for slot k.
REQ-012 SHALL have port in_slot_data, output, NUM_SLOTS*20 bits: the last received frame, packed the same way as out_slot_data.
REQ-013 SHALL have port in_slot_valid, output, NUM_SLOTS bits: input tag bits 14..(15-NUM_SLOTS) of the last received frame.
REQ-014 SHALL have port in_frame_strobe, output, 1 bit: one-cycle pulse when in_* updates.
REQ-015 SHALL have port link_up, output, 1 bit: high when the state is RUN.
REQ-016 SHALL have port frame_count, output, 16 bits: count of frames started; wraps from 65535 to 0.

Function
REQ-017 SHALL keep an 8-bit bit counter bitcnt that increments every rising edge and wraps 255->0; cycle k is the cycle in which bitcnt==k.
REQ-018 SHALL frame bits as: bit 0 = tag[15], the MSB; bits 0..15 = tag; slot n occupies bits 16+20(n-1) .. 35+20(n-1), MSB first.
REQ-019 SHALL present frame bit k on ac97_sdata_out and sync=(k<16) during cycle k, with both flopped on the preceding rising edge.
REQ-020 SHALL assert ac97_strobe combinationally exactly when bitcnt==255.
REQ-021 SHALL capture out_slot_data and out_slot_valid into a shadow register at the rising edge ending cycle 255; the next frame uses only the shadow, so upstream may change the inputs at any other time.
REQ-022 SHALL build the tag in RUN as: tag[15]=1, tag[15-n]=shadow valid n, unused tag bits 0; a slot with valid 0 is sent as 20'h0.
REQ-023 SHALL build the tag in WAIT_READY as all zeros, with all slot data zero.
REQ-024 SHALL sample ac97_sdata_in on the falling edge of ac97_bitclk into frame bit position bitcnt.
REQ-025 SHALL, at the rising edge ending cycle 255, publish the assembled frame to in_slot_data and in_slot_valid, and pulse in_frame_strobe high for cycle 0.
REQ-026 SHALL implement a two-state FSM, WAIT_READY and RUN, evaluated only at the rising edge ending cycle 255, using the input tag[15] just received.
REQ-027 SHALL update a 4-bit rdy_cnt each frame: if tag[15]=1, rdy_cnt increments, saturating at 15; otherwise rdy_cnt clears to 0.
REQ-028 SHALL move from WAIT_READY to RUN when the updated rdy_cnt is >= READY_FRAMES.
REQ-029 SHALL move from RUN to WAIT_READY on any frame with tag[15]=0.
REQ-030 SHALL apply a state change at the same edge as the shadow capture, so the frame that starts at that edge already uses the new state's tag rules.
REQ-031 SHALL increment frame_count at each rising edge that ends cycle 255.

Reset
REQ-032 SHALL, while ac97_rst=1, force bitcnt=255, sdata_out=0, sync=0, shadow=0, in_slot_data=0, in_slot_valid=0, in_frame_strobe=0, rdy_cnt=0, frame_count=0, state=WAIT_READY.
REQ-033 SHALL have ac97_strobe=1 in the first cycle after reset, so the first frame starts cleanly.
REQ-034 SHALL, on reset mid-frame, abandon the partial input frame; no in_frame_strobe is generated for it.

Structure
REQ-035 SHALL place in shared package ac97_pkg: FRAME_BITS=256, TAG_BITS=16, SLOT_W=20, MAX_SLOTS=12, and the link state enum.
REQ-036 SHALL put falling-edge capture and frame publish in sub-module ac97_frame_deser.

Verification
REQ-037 SHALL cover: codec tag[15]=1 from frame 0, READY_FRAMES=2 -> link_up rises at the end of the 2nd received frame; frames 0..2 sent with tag 16'h0000; frame 3 tag[15]=1.
REQ-038 SHALL cover: in RUN, slot3 valid with 20'hABCD0, slot4 invalid with 20'h12345 -> tag 16'h9000 (bits 15,12 set), slot3 bits exactly 20'hABCD0, slot4 all zeros.
REQ-039 SHALL cover: out_slot_data changed during cycle 100 -> no effect on the current frame; the value held at the cycle-255 edge goes out in the next frame.
REQ-040 SHALL cover: codec sends slot1 20'hFFFFF with in tag 16'hC000 -> in_slot_data[19:0]=20'hFFFFF, in_slot_valid[0]=1, in_frame_strobe high for exactly one cycle (cycle 0).
REQ-041 SHALL cover: in RUN, one codec frame with tag[15]=0 -> link_up falls at that frame's end; the next frame is sent all zeros and rdy_cnt=0.
REQ-042 SHALL cover: ac97_rst pulsed at cycle 37 -> all outputs at reset values, ac97_reset_b=0 during the pulse, no stale in_frame_strobe, and frame_count continues from 0 at 1.

Source files
------------

// File: rtl/ac97_pkg.sv
// Shared AC'97 link constants and the link state type.
package ac97_pkg;

  localparam int unsigned FRAME_BITS = 256;
  localparam int unsigned TAG_BITS   = 16;
  localparam int unsigned SLOT_W     = 20;
  localparam int unsigned MAX_SLOTS  = 12;
  localparam int unsigned BITCNT_W   = 8;

  typedef enum logic {
    ST_WAIT_READY = 1'b0,
    ST_RUN        = 1'b1
  } link_state_e;

endpackage

// File: rtl/ac97_frame_deser.sv
// Falling-edge capture of the inbound AC'97 frame and publish of complete frames.
module ac97_frame_deser
  import ac97_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 12
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        sdata_i,
  input  logic [BITCNT_W-1:0]         bitcnt_i,
  input  logic                        frame_end_i,
  output logic [NUM_SLOTS*SLOT_W-1:0] in_slot_data_o,
  output logic [NUM_SLOTS-1:0]        in_slot_valid_o,
  output logic                        in_frame_strobe_o,
  output logic                        frame_done_c,
  output logic                        rx_ready_c
);

  logic [FRAME_BITS-1:0]       cap_q;
  logic                        armed_q;
  logic [NUM_SLOTS*SLOT_W-1:0] in_data_q;
  logic [NUM_SLOTS*SLOT_W-1:0] in_data_d;
  logic [NUM_SLOTS-1:0]        in_valid_q;
  logic [NUM_SLOTS-1:0]        in_valid_d;
  logic                        in_strobe_q;
  logic                        unused_cap_c;

  // Frame bit k lands at vector index 255-k, so the tag sits at the top.
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cap_q <= '0;
    end else begin
      cap_q[~bitcnt_i] <= sdata_i;
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_unpack
    assign in_data_d[g*SLOT_W +: SLOT_W] = cap_q[FRAME_BITS-TAG_BITS-1-g*SLOT_W -: SLOT_W];
    assign in_valid_d[g]                 = cap_q[FRAME_BITS-2-g];
  end

  // The frame cut short by reset is never published: armed_q waits for a clean frame start.
  assign frame_done_c = frame_end_i & armed_q;
  assign rx_ready_c   = cap_q[FRAME_BITS-1];
  assign unused_cap_c = ^cap_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      armed_q     <= 1'b0;
      in_data_q   <= '0;
      in_valid_q  <= '0;
      in_strobe_q <= 1'b0;
    end else begin
      in_strobe_q <= frame_done_c;
      if (frame_end_i) begin
        armed_q <= 1'b1;
      end
      if (frame_done_c) begin
        in_data_q  <= in_data_d;
        in_valid_q <= in_valid_d;
      end
    end
  end

  assign in_slot_data_o    = in_data_q;
  assign in_slot_valid_o   = in_valid_q;
  assign in_frame_strobe_o = in_strobe_q;

endmodule

// File: rtl/ac97_link_engine.sv
// AC'97 controller link: frame timing, outbound serialisation and codec-ready tracking.
module ac97_link_engine
  import ac97_pkg::*;
#(
  parameter int unsigned NUM_SLOTS    = 12,
  parameter int unsigned READY_FRAMES = 2
) (
  input  logic                        ac97_bitclk,
  input  logic                        ac97_rst,
  input  logic                        ac97_sdata_in,
  output logic                        ac97_sdata_out,
  output logic                        ac97_sync,
  output logic                        ac97_reset_b,
  output logic                        ac97_strobe,
  input  logic [NUM_SLOTS*SLOT_W-1:0] out_slot_data,
  input  logic [NUM_SLOTS-1:0]        out_slot_valid,
  output logic [NUM_SLOTS*SLOT_W-1:0] in_slot_data,
  output logic [NUM_SLOTS-1:0]        in_slot_valid,
  output logic                        in_frame_strobe,
  output logic                        link_up,
  output logic [15:0]                 frame_count
);

  logic [BITCNT_W-1:0]         bitcnt_q;
  logic [BITCNT_W-1:0]         nxt_bit_c;
  logic                        strobe_c;
  logic                        sdata_q;
  logic                        sdata_d;
  logic                        sync_q;
  logic                        sync_d;
  logic [NUM_SLOTS*SLOT_W-1:0] shadow_data_q;
  logic [NUM_SLOTS-1:0]        shadow_valid_q;
  link_state_e                 state_q;
  link_state_e                 state_d;
  logic [3:0]                  rdy_cnt_q;
  logic [3:0]                  rdy_cnt_d;
  logic [3:0]                  rdy_upd_c;
  logic [15:0]                 frame_count_q;
  logic                        frame_done_c;
  logic                        rx_ready_c;
  logic [MAX_SLOTS-1:0]        tx_vrev_c;
  logic [MAX_SLOTS*SLOT_W-1:0] tx_body_c;
  logic [FRAME_BITS-1:0]       tx_frame_c;

  assign strobe_c     = (bitcnt_q == BITCNT_W'(FRAME_BITS - 1));
  assign nxt_bit_c    = bitcnt_q + BITCNT_W'(1);
  assign ac97_strobe  = strobe_c;
  assign ac97_reset_b = ~ac97_rst;

  // Outbound frame image, slot 1 first; slots above NUM_SLOTS stay invalid and zero.
  for (genvar g = 0; g < MAX_SLOTS; g++) begin : g_slot
    if (g < NUM_SLOTS) begin : g_used
      assign tx_vrev_c[MAX_SLOTS-1-g] = shadow_valid_q[g];
      assign tx_body_c[(MAX_SLOTS-1-g)*SLOT_W +: SLOT_W] =
        shadow_valid_q[g] ? shadow_data_q[g*SLOT_W +: SLOT_W] : '0;
    end else begin : g_unused
      assign tx_vrev_c[MAX_SLOTS-1-g] = 1'b0;
      assign tx_body_c[(MAX_SLOTS-1-g)*SLOT_W +: SLOT_W] = '0;
    end
  end

  assign tx_frame_c = (state_q == ST_RUN)
                    ? {1'b1, tx_vrev_c, {(TAG_BITS-1-MAX_SLOTS){1'b0}}, tx_body_c}
                    : '0;

  // Codec-ready tracking; only moves when a complete inbound frame is published.
  always_comb begin
    state_d   = state_q;
    rdy_cnt_d = rdy_cnt_q;
    rdy_upd_c = '0;
    if (frame_done_c) begin
      if (rx_ready_c) begin
        rdy_upd_c = (rdy_cnt_q == 4'hF) ? 4'hF : rdy_cnt_q + 4'd1;
      end
      rdy_cnt_d = rdy_upd_c;
      if (state_q == ST_WAIT_READY) begin
        if (32'(rdy_upd_c) >= READY_FRAMES) begin
          state_d = ST_RUN;
        end
      end else if (!rx_ready_c) begin
        state_d = ST_WAIT_READY;
      end
    end
  end

  // Bit 0 of a new frame is tag[15], which follows the state being entered at this edge.
  always_comb begin
    sync_d  = (nxt_bit_c < BITCNT_W'(TAG_BITS));
    sdata_d = tx_frame_c[~nxt_bit_c];
    if (strobe_c) begin
      sdata_d = (state_d == ST_RUN);
    end
  end

  always_ff @(posedge ac97_bitclk or posedge ac97_rst) begin
    if (ac97_rst) begin
      bitcnt_q       <= BITCNT_W'(FRAME_BITS - 1);
      sdata_q        <= 1'b0;
      sync_q         <= 1'b0;
      shadow_data_q  <= '0;
      shadow_valid_q <= '0;
      state_q        <= ST_WAIT_READY;
      rdy_cnt_q      <= '0;
      frame_count_q  <= '0;
    end else begin
      bitcnt_q  <= nxt_bit_c;
      sdata_q   <= sdata_d;
      sync_q    <= sync_d;
      state_q   <= state_d;
      rdy_cnt_q <= rdy_cnt_d;
      if (strobe_c) begin
        shadow_data_q  <= out_slot_data;
        shadow_valid_q <= out_slot_valid;
        frame_count_q  <= frame_count_q + 16'd1;
      end
    end
  end

  ac97_frame_deser #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_deser (
    .clk_i             (ac97_bitclk),
    .rst_i             (ac97_rst),
    .sdata_i           (ac97_sdata_in),
    .bitcnt_i          (bitcnt_q),
    .frame_end_i       (strobe_c),
    .in_slot_data_o    (in_slot_data),
    .in_slot_valid_o   (in_slot_valid),
    .in_frame_strobe_o (in_frame_strobe),
    .frame_done_c      (frame_done_c),
    .rx_ready_c        (rx_ready_c)
  );

  assign ac97_sdata_out = sdata_q;
  assign ac97_sync      = sync_q;
  assign link_up        = (state_q == ST_RUN);
  assign frame_count    = frame_count_q;

endmodule

// File: tb/tb_ac97_link_engine.sv
// Directed bench for ac97_link_engine: link bring-up, slot framing, shadowing, drop-out and reset.
module tb_ac97_link_engine;

  logic         clk;
  logic         rst;
  logic         sdata_in;
  logic         sdata_out;
  logic         sync;
  logic         reset_b;
  logic         strobe;
  logic [239:0] out_data;
  logic [11:0]  out_valid;
  logic [239:0] in_data;
  logic [11:0]  in_valid;
  logic         in_fs;
  logic         link_up;
  logic [15:0]  frame_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   tb_bit;
  int           tb_frame;
  logic [255:0] codec_tx;
  logic [255:0] codec_next;
  logic [255:0] tx_shift;
  logic [255:0] sync_shift;
  logic [255:0] tx_last;
  logic [255:0] sync_last;
  logic [255:0] ready_frame;
  logic [255:0] exp_frame;

  ac97_link_engine #(
    .NUM_SLOTS    (12),
    .READY_FRAMES (2)
  ) dut (
    .ac97_bitclk     (clk),
    .ac97_rst        (rst),
    .ac97_sdata_in   (sdata_in),
    .ac97_sdata_out  (sdata_out),
    .ac97_sync       (sync),
    .ac97_reset_b    (reset_b),
    .ac97_strobe     (strobe),
    .out_slot_data   (out_data),
    .out_slot_valid  (out_valid),
    .in_slot_data    (in_data),
    .in_slot_valid   (in_valid),
    .in_frame_strobe (in_fs),
    .link_up         (link_up),
    .frame_count     (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side frame position: cycle index within the frame and frames started since reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tb_bit   <= 8'd255;
      tb_frame <= 0;
    end else begin
      tb_bit <= tb_bit + 8'd1;
      if (tb_bit == 8'd255) tb_frame <= tb_frame + 1;
    end
  end

  // Codec model: a new frame image is taken at each frame boundary, driven MSB first.
  always @(posedge clk) begin
    if (tb_bit == 8'd255) codec_tx <= codec_next;
  end
  assign sdata_in = codec_tx[~tb_bit];

  // Record each outbound frame and its sync pattern mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      tx_shift[~tb_bit]   = sdata_out;
      sync_shift[~tb_bit] = sync;
      if (tb_bit == 8'd255) begin
        tx_last   = tx_shift;
        sync_last = sync_shift;
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int f, input logic [7:0] b);
    int n = 0;
    while (!(tb_frame == f && tb_bit == b) && n < 2000) begin
      tick();
      n++;
    end
    chk("reach", 256'(tb_frame == f && tb_bit == b), 256'd1);
  endtask

  initial begin
    rst        = 1'b1;
    codec_tx   = '0;
    out_data   = '0;
    out_valid  = '0;
    tx_shift   = '0;
    sync_shift = '0;
    tx_last    = '0;
    sync_last  = '0;
    // Codec ready frame: tag C000 (ready + slot1 valid), slot1 = FFFFF.
    ready_frame          = '0;
    ready_frame[255:240] = 16'hC000;
    ready_frame[239:220] = 20'hFFFFF;
    codec_next           = ready_frame;
    // Outbound: slot3 valid ABCD0, slot4 invalid 12345.
    out_data[59:40] = 20'hABCD0;
    out_data[79:60] = 20'h12345;
    out_valid[2]    = 1'b1;

    tick();
    tick();
    chk("rst_sdata", 256'(sdata_out), 256'd0);
    chk("rst_sync", 256'(sync), 256'd0);
    chk("rst_reset_b", 256'(reset_b), 256'd0);
    chk("rst_link", 256'(link_up), 256'd0);
    chk("rst_fcount", 256'(frame_count), 256'd0);
    chk("rst_in_fs", 256'(in_fs), 256'd0);
    chk("rst_in_data", 256'(in_data), 256'd0);
    rst = 1'b0;
    #1;
    chk("strobe_first", 256'(strobe), 256'd1);
    chk("reset_b_run", 256'(reset_b), 256'd1);

    run_to(1, 8'd0);
    chk("fcount_1", 256'(frame_count), 256'd1);
    chk("no_stub_fs", 256'(in_fs), 256'd0);
    chk("strobe_bit0", 256'(strobe), 256'd0);

    // End of first codec frame: published, but only one ready frame so far.
    run_to(2, 8'd0);
    chk("in_fs_pulse", 256'(in_fs), 256'd1);
    chk("in_slot1", 256'(in_data[19:0]), 256'h0FFFFF);
    chk("in_valid", 256'(in_valid), 256'h001);
    chk("link_f2", 256'(link_up), 256'd0);
    chk("tx_frame1", tx_last, 256'd0);
    run_to(2, 8'd1);
    chk("in_fs_one", 256'(in_fs), 256'd0);

    run_to(3, 8'd0);
    chk("link_up", 256'(link_up), 256'd1);
    chk("tx_frame2", tx_last, 256'd0);
    chk("sync_shape", sync_last, {16'hFFFF, 240'd0});
    chk("fcount_3", 256'(frame_count), 256'd3);

    // First RUN frame: tag 9000, slot3 ABCD0, slot4 suppressed.
    run_to(4, 8'd0);
    exp_frame            = '0;
    exp_frame[255:240]   = 16'h9000;
    exp_frame[199:180]   = 20'hABCD0;
    chk("tx_frame3", tx_last, exp_frame);

    run_to(4, 8'd100);
    out_data[59:40] = 20'h55AA5;
    run_to(5, 8'd0);
    chk("tx_shadow_hold", tx_last, exp_frame);
    run_to(6, 8'd0);
    exp_frame[199:180] = 20'h55AA5;
    chk("tx_shadow_new", tx_last, exp_frame);

    // One codec frame without ready drops the link.
    codec_next = '0;
    run_to(7, 8'd0);
    chk("link_hold", 256'(link_up), 256'd1);
    codec_next = ready_frame;
    run_to(8, 8'd0);
    chk("link_drop", 256'(link_up), 256'd0);
    chk("drop_fs", 256'(in_fs), 256'd1);
    chk("drop_valid", 256'(in_valid), 256'd0);
    chk("drop_data", 256'(in_data), 256'd0);
    run_to(9, 8'd0);
    chk("tx_after_drop", tx_last, 256'd0);
    chk("link_f9", 256'(link_up), 256'd0);
    run_to(10, 8'd0);
    chk("relink", 256'(link_up), 256'd1);
    chk("tx_frame9", tx_last, 256'd0);

    // Reset mid-frame.
    run_to(10, 8'd37);
    rst = 1'b1;
    #1;
    chk("mrst_sdata", 256'(sdata_out), 256'd0);
    chk("mrst_sync", 256'(sync), 256'd0);
    chk("mrst_reset_b", 256'(reset_b), 256'd0);
    chk("mrst_strobe", 256'(strobe), 256'd1);
    chk("mrst_link", 256'(link_up), 256'd0);
    chk("mrst_fcount", 256'(frame_count), 256'd0);
    chk("mrst_in_data", 256'(in_data), 256'd0);
    chk("mrst_in_valid", 256'(in_valid), 256'd0);
    chk("mrst_in_fs", 256'(in_fs), 256'd0);
    tick();
    tick();
    chk("mrst_reset_b_hold", 256'(reset_b), 256'd0);
    rst = 1'b0;
    run_to(1, 8'd0);
    chk("post_rst_fcount", 256'(frame_count), 256'd1);
    chk("post_rst_no_fs", 256'(in_fs), 256'd0);
    run_to(2, 8'd0);
    chk("post_rst_fs", 256'(in_fs), 256'd1);
    chk("post_rst_link", 256'(link_up), 256'd0);
    chk("post_rst_fcount2", 256'(frame_count), 256'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
